// File: rtl/btn_event_decoder.sv
`default_nettype none
// ============================================================================
// btn_event_decoder : debounced button level -> press/short/long/repeat/release
// Revision 1.0
// ============================================================================
module btn_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic db_btn_i,
    output logic held_o,
    output logic press_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic release_o
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Terminal counts: the counter restarts at 0 on the press/long edge, so
    // the event fires on the edge that sees count == N-1.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             held_nx, press_nx, short_nx, long_nx, repeat_nx, release_nx;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            count     <= '0;
            held_o    <= 1'b0;
            press_o   <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            release_o <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            held_o    <= held_nx;
            press_o   <= press_nx;
            short_o   <= short_nx;
            long_o    <= long_nx;
            repeat_o  <= repeat_nx;
            release_o <= release_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        press_nx   = 1'b0;
        short_nx   = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        release_nx = 1'b0;

        // Release is tested first so it overrides a coincident long/repeat.
        case (state)
            IDLE: begin
                if (db_btn_i) begin
                    state_nx = PRESSED;
                    count_nx = '0;
                    press_nx = 1'b1;
                end
            end
            PRESSED: begin
                if (!db_btn_i) begin
                    state_nx   = IDLE;
                    count_nx   = '0;
                    release_nx = 1'b1;
                    short_nx   = 1'b1;
                end else if (count == LONG_LAST) begin
                    state_nx = LONG;
                    count_nx = '0;
                    long_nx  = 1'b1;
                end else begin
                    count_nx = count + CNT_ONE;
                end
            end
            LONG: begin
                if (!db_btn_i) begin
                    state_nx   = IDLE;
                    count_nx   = '0;
                    release_nx = 1'b1;
                end else if (count == REPEAT_LAST) begin
                    count_nx  = '0;
                    repeat_nx = 1'b1;
                end else begin
                    count_nx = count + CNT_ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase

        held_nx = (state_nx == PRESSED) || (state_nx == LONG);
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_decoder.sv
`default_nettype none
// ============================================================================
// tb_btn_event_decoder : directed + random stimulus against an event-time model
// Revision 1.0
// ============================================================================
module tb_btn_event_decoder;

    localparam int LONG   = 8;
    localparam int REPEAT = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic db_btn_i;
    logic held_o, press_o, short_o, long_o, repeat_o, release_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles elapsed since the press_o cycle, and whether long fired.
    bit m_held;
    int m_age;
    bit m_long;
    logic e_held, e_press, e_short, e_long, e_repeat, e_release;

    btn_event_decoder #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .db_btn_i  (db_btn_i),
        .held_o    (held_o),
        .press_o   (press_o),
        .short_o   (short_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o),
        .release_o (release_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_age = 0; m_long = 0;
        e_held = 0; e_press = 0; e_short = 0; e_long = 0; e_repeat = 0; e_release = 0;
    endtask

    task automatic model_edge(input bit b);
        e_press = 0; e_short = 0; e_long = 0; e_repeat = 0; e_release = 0;
        if (!m_held) begin
            if (b) begin
                e_press = 1; m_held = 1; m_age = 0; m_long = 0;
            end
        end else if (!b) begin
            e_release = 1;
            e_short   = !m_long;
            m_held    = 0;
        end else begin
            m_age++;
            if (m_age == LONG) begin
                e_long = 1; m_long = 1;
            end else if (m_age > LONG && ((m_age - LONG) % REPEAT) == 0) begin
                e_repeat = 1;
            end
        end
        e_held = m_held;
    endtask

    task automatic check_all();
        check("held",    held_o,    e_held);
        check("press",   press_o,   e_press);
        check("short",   short_o,   e_short);
        check("long",    long_o,    e_long);
        check("repeat",  repeat_o,  e_repeat);
        check("release", release_o, e_release);
        check("pulse_exclusive", $onehot0({press_o, long_o, repeat_o, release_o}), 1'b1);
        check("short_with_release", (!short_o) || release_o, 1'b1);
    endtask

    // Called at a negedge; presents b to the next posedge and checks after it.
    task automatic step(input bit b);
        db_btn_i = b;
        @(posedge clk_i);
        model_edge(b);
        #1;
        check_all();
        @(negedge clk_i);
    endtask

    task automatic steps(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    initial begin
        int hold;
        int gap;
        rst_i    = 1'b0;
        db_btn_i = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check_all();
        end
        @(negedge clk_i);
        rst_i = 1'b1;

        // Idle after reset
        steps(0, 20);
        // Short click: held for 3 edges
        steps(1, 3); steps(0, 4);
        // Long hold with two repeats
        steps(1, 20); steps(0, 4);
        // Release on exactly the long edge
        steps(1, 8); steps(0, 4);
        // Back-to-back press
        step(1); step(1); step(0); step(1); steps(0, 3);

        // Asynchronous reset while in LONG, then button held through deassertion
        steps(1, 10);
        check("in_long_before_reset", m_long, 1'b1);
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i);
            #1;
            check_all();
        end
        @(negedge clk_i);
        db_btn_i = 1'b1;
        rst_i    = 1'b1;
        step(1);
        check("press_after_reset", press_o, 1'b1);
        steps(1, 2); steps(0, 3);

        // Random hold/gap lengths
        for (int r = 0; r < 400; r++) begin
            hold = $urandom_range(1, 30);
            gap  = $urandom_range(1, 3);
            steps(1, hold);
            steps(0, gap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
